// File: rtl/iface_item_producer_pkg.sv
// Shared types for the myiface producer/consumer slice.
// item_t is the width of one displayed item; prod_state_e is the producer FSM encoding.
package myiface_pkg;

    typedef logic [2:0] item_t;

    localparam item_t ITEM_IDLE_DEFAULT = 3'b000;

    typedef enum logic {
        PS_IDLE,
        PS_SHOW
    } prod_state_e;

endpackage

// File: rtl/iface_item_producer_if.sv
// myiface: one item bus written by a producer stage and read by the consumer chain.
interface myiface;
    import myiface_pkg::*;

    item_t item;

    modport producer (output item);
    modport consumer (input item);

endinterface

// File: rtl/iface_item_producer_fifo.sv
// item_fifo: small power-of-two FIFO of items with a combinational head (pop_data).
// Occupancy is kept one bit wider than the pointers so full and empty differ.
module item_fifo
    import myiface_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  item_t                  push_data,
    input  logic                   pop,
    output item_t                  pop_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    item_t          mem [DEPTH];
    logic [AW-1:0]  wptr;
    logic [AW-1:0]  rptr;
    logic           do_push;
    logic           do_pop;

    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + 1'b1;
            end
            if (do_pop) begin
                rptr <= rptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; a push and a pop never target the same slot.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= push_data;
        end
    end

endmodule

// File: rtl/iface_item_producer.sv
// iface_item_producer: buffers upstream items and shows each on iface.item for HOLD cycles,
// back to back while the FIFO has data, IDLE_ITEM otherwise.
module iface_item_producer
    import myiface_pkg::*;
#(
    parameter int    DEPTH     = 4,
    parameter int    HOLD      = 2,
    parameter item_t IDLE_ITEM = ITEM_IDLE_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  item_t                  in_item,
    output logic                   in_ready,
    myiface.producer               iface,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] count
);

    localparam int            HW          = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [HW-1:0] HOLD_RELOAD = HW'(HOLD - 1);

    prod_state_e    state;
    logic [HW-1:0]  hold_cnt;
    item_t          item_q;
    item_t          head;
    logic           full;
    logic           empty;
    logic           push;
    logic           pop;

    assign in_ready   = !full;
    assign push       = in_valid && in_ready;
    assign iface.item = item_q;

    // Pop whenever a new item is about to be latched into the display register.
    always_comb begin
        pop = 1'b0;
        if (!empty) begin
            case (state)
                PS_IDLE: pop = 1'b1;
                PS_SHOW: pop = (hold_cnt == '0);
                default: pop = 1'b0;
            endcase
        end
    end

    item_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_data(in_item),
        .pop      (pop),
        .pop_data (head),
        .full     (full),
        .empty    (empty),
        .count    (count)
    );

    // busy is registered alongside item_q so both change on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= PS_IDLE;
            hold_cnt <= '0;
            item_q   <= IDLE_ITEM;
            busy     <= 1'b0;
        end else begin
            case (state)
                PS_IDLE: begin
                    if (!empty) begin
                        item_q   <= head;
                        hold_cnt <= HOLD_RELOAD;
                        state    <= PS_SHOW;
                        busy     <= 1'b1;
                    end
                end
                PS_SHOW: begin
                    if (hold_cnt != '0) begin
                        hold_cnt <= hold_cnt - 1'b1;
                    end else if (!empty) begin
                        item_q   <= head;
                        hold_cnt <= HOLD_RELOAD;
                    end else begin
                        item_q <= IDLE_ITEM;
                        state  <= PS_IDLE;
                        busy   <= 1'b0;
                    end
                end
                default: begin
                    item_q <= IDLE_ITEM;
                    state  <= PS_IDLE;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iface_item_producer.sv
// Bench for iface_item_producer: two instances (HOLD=2 and HOLD=8) checked cycle by cycle
// against a schedule model that derives each item's display window from its accept cycle.
module tb_iface_item_producer;
    import myiface_pkg::*;

    localparam int DEPTH  = 4;
    localparam int HOLD_A = 2;
    localparam int HOLD_B = 8;
    localparam int MAXREC = 512;

    logic       clk     = 1'b0;
    logic       rst     = 1'b1;
    logic       a_valid = 1'b0;
    logic       b_valid = 1'b0;
    item_t      a_item  = '0;
    item_t      b_item  = '0;
    logic       a_ready, b_ready, a_busy, b_busy;
    logic [2:0] a_count, b_count;

    myiface ifa ();
    myiface ifb ();

    iface_item_producer #(.DEPTH(DEPTH), .HOLD(HOLD_A), .IDLE_ITEM(3'b000)) dut_a (
        .clk(clk), .rst(rst), .in_valid(a_valid), .in_item(a_item),
        .in_ready(a_ready), .iface(ifa), .busy(a_busy), .count(a_count)
    );

    iface_item_producer #(.DEPTH(DEPTH), .HOLD(HOLD_B), .IDLE_ITEM(3'b000)) dut_b (
        .clk(clk), .rst(rst), .in_valid(b_valid), .in_item(b_item),
        .in_ready(b_ready), .iface(ifb), .busy(b_busy), .count(b_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Model: every accepted item with its accept cycle and the cycle its display starts.
    item_t rec_d [2][MAXREC];
    int    rec_a [2][MAXREC];
    int    rec_s [2][MAXREC];
    int    nrec  [2];

    function automatic int hold_of(int w);
        return (w == 0) ? HOLD_A : HOLD_B;
    endfunction

    function automatic void model_clear();
        nrec[0] = 0;
        nrec[1] = 0;
    endfunction

    // Shown at max(accept+2, end of previous display); gaps fall out of the max.
    function automatic void model_accept(int w, int c, item_t d);
        int s = c + 2;
        int n = nrec[w];
        if (n > 0 && rec_s[w][n-1] + hold_of(w) > s) s = rec_s[w][n-1] + hold_of(w);
        if (n < MAXREC) begin
            rec_d[w][n] = d;
            rec_a[w][n] = c;
            rec_s[w][n] = s;
            nrec[w]     = n + 1;
        end
    endfunction

    function automatic int m_count(int w, int c);
        int n = 0;
        for (int i = 0; i < nrec[w]; i++)
            if (rec_a[w][i] < c && rec_s[w][i] > c) n++;
        return n;
    endfunction

    function automatic logic [7:0] exp_vec(int w, int c);
        int    cnt  = m_count(w, c);
        logic  bsy  = 1'b0;
        item_t itm  = 3'b000;
        for (int i = 0; i < nrec[w]; i++)
            if (rec_s[w][i] <= c && c < rec_s[w][i] + hold_of(w)) begin
                bsy = 1'b1;
                itm = rec_d[w][i];
            end
        return {(cnt < DEPTH), bsy, 3'(cnt), itm};
    endfunction

    function automatic logic [7:0] obs_vec(int w);
        return (w == 0) ? {a_ready, a_busy, a_count, ifa.item}
                        : {b_ready, b_busy, b_count, ifb.item};
    endfunction

    // One cycle: drive DUT w after the edge, record the accept, stop at the falling edge.
    task automatic applyStimulus(input int w, input logic v, input item_t d, output logic acc);
        @(posedge clk);
        #1;
        a_valid = 1'b0;
        b_valid = 1'b0;
        if (w == 0) begin a_valid = v; a_item = d; end
        else        begin b_valid = v; b_item = d; end
        acc = v && !rst && (m_count(w, cyc) < DEPTH);
        if (acc) model_accept(w, cyc, d);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        a_valid = 1'b0;
        b_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; a_valid = 1'b1; b_valid = 1'b1; a_item = 3'b110; b_item = 3'b011;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            if (k == 2) begin rst = 1'b0; a_valid = 1'b0; b_valid = 1'b0; end
            @(negedge clk);
            for (int w = 0; w < 2; w++) begin
                checks++;
                if (obs_vec(w) !== 8'h80) begin
                    errors++;
                    $display("[TB] FAIL reset_state dut=%0d k=%0d got %h exp %h", w, k, obs_vec(w), 8'h80);
                end
            end
        end
        model_clear();
    endtask

    task automatic test_single();
        item_t exp_item [6] = '{3'd0, 3'd0, 3'd5, 3'd5, 3'd0, 3'd0};
        logic  exp_busy [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        logic  acc;
        for (int j = 0; j < 6; j++) begin
            applyStimulus(0, j == 0, 3'b101, acc);
            checks++;
            if (ifa.item !== exp_item[j] || a_busy !== exp_busy[j]) begin
                errors++;
                $display("[TB] FAIL single_item j=%0d got item %h busy %b exp item %h busy %b",
                         j, ifa.item, a_busy, exp_item[j], exp_busy[j]);
            end
            checks++;
            if (obs_vec(0) !== exp_vec(0, cyc)) begin
                errors++;
                $display("[TB] FAIL single_model j=%0d got %h exp %h", j, obs_vec(0), exp_vec(0, cyc));
            end
        end
    endtask

    task automatic test_burst();
        item_t exp_item [10] = '{3'd0, 3'd0, 3'd1, 3'd1, 3'd2, 3'd2, 3'd3, 3'd3, 3'd0, 3'd0};
        logic  acc;
        int    peak = 0;
        for (int j = 0; j < 10; j++) begin
            applyStimulus(0, j < 3, item_t'(j + 1), acc);
            if (int'(a_count) > peak) peak = int'(a_count);
            checks++;
            if (ifa.item !== exp_item[j] || obs_vec(0) !== exp_vec(0, cyc)) begin
                errors++;
                $display("[TB] FAIL burst j=%0d got %h exp item %h vec %h", j, obs_vec(0), exp_item[j], exp_vec(0, cyc));
            end
        end
        checks++;
        if (peak !== 2) begin
            errors++;
            $display("[TB] FAIL burst_peak got %0d exp 2", peak);
        end
    endtask

    task automatic test_full();
        item_t vals [10];
        int    idx = 0;
        int    busy_cycles = 0;
        logic  saw_full = 1'b0;
        logic  acc;
        for (int i = 0; i < 10; i++) vals[i] = item_t'($urandom_range(1, 7));
        for (int j = 0; j < 110; j++) begin
            applyStimulus(1, idx < 10, vals[(idx < 10) ? idx : 9], acc);
            if (acc) idx++;
            if (b_busy === 1'b1) busy_cycles++;
            if (b_ready === 1'b0) saw_full = 1'b1;
            checks++;
            if (obs_vec(1) !== exp_vec(1, cyc)) begin
                errors++;
                $display("[TB] FAIL full_model j=%0d got %h exp %h", j, obs_vec(1), exp_vec(1, cyc));
            end
        end
        checks++;
        if (saw_full !== 1'b1) begin
            errors++;
            $display("[TB] FAIL full_ready_drop got %b exp 1", saw_full);
        end
        checks++;
        if (busy_cycles !== 10 * HOLD_B) begin
            errors++;
            $display("[TB] FAIL full_shown_cycles got %0d exp %0d", busy_cycles, 10 * HOLD_B);
        end
    endtask

    task automatic test_simul();
        logic acc;
        for (int j = 0; j < 12; j++) begin
            applyStimulus(0, j < 4, item_t'(j + 4), acc);
            if (j == 3 || j == 4) begin
                checks++;
                if (a_count !== 3'd2) begin
                    errors++;
                    $display("[TB] FAIL simul_count j=%0d got %0d exp 2", j, a_count);
                end
            end
            checks++;
            if (obs_vec(0) !== exp_vec(0, cyc)) begin
                errors++;
                $display("[TB] FAIL simul_model j=%0d got %h exp %h", j, obs_vec(0), exp_vec(0, cyc));
            end
        end
    endtask

    task automatic test_reset_mid();
        logic acc;
        for (int j = 0; j < 6; j++) applyStimulus(0, j < 5, item_t'(j + 1), acc);
        @(posedge clk);
        #1;
        rst = 1'b1;
        a_valid = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        a_valid = 1'b0;
        model_clear();
        @(negedge clk);
        checks++;
        if (obs_vec(0) !== 8'h80) begin
            errors++;
            $display("[TB] FAIL reset_mid_state got %h exp %h", obs_vec(0), 8'h80);
        end
        for (int j = 0; j < 5; j++) begin
            applyStimulus(0, j == 0, 3'b011, acc);
            checks++;
            if (ifa.item !== ((j == 2 || j == 3) ? 3'b011 : 3'b000) || obs_vec(0) !== exp_vec(0, cyc)) begin
                errors++;
                $display("[TB] FAIL reset_mid_push j=%0d got %h exp %h", j, obs_vec(0), exp_vec(0, cyc));
            end
        end
    endtask

    task automatic test_random(input int w);
        logic acc;
        for (int j = 0; j < 150; j++) begin
            applyStimulus(w, $urandom_range(0, 3) != 0, item_t'($urandom_range(0, 7)), acc);
            checks++;
            if (obs_vec(w) !== exp_vec(w, cyc)) begin
                errors++;
                $display("[TB] FAIL random dut=%0d j=%0d got %h exp %h", w, j, obs_vec(w), exp_vec(w, cyc));
            end
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_single();
        do_reset();
        test_burst();
        do_reset();
        test_full();
        do_reset();
        test_simul();
        do_reset();
        test_reset_mid();
        do_reset();
        test_random(0);
        do_reset();
        test_random(1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
